// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared widths and state encoding for the nibble deserializer
package nibble_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 32;
  localparam int NIBBLES_PER_WORD = 8;

  typedef enum logic {
    DS_IDLE,
    DS_COLLECT
  } deser_state_t;

  // New nibbles enter at the top so the first one ends up in the low bits.
  function automatic logic [WORD_W-1:0] shift_nibble(input logic [WORD_W-1:0] cur,
                                                      input logic [NIBBLE_W-1:0] nib);
    return {nib, cur[WORD_W-1:NIBBLE_W]};
  endfunction

endpackage

// File: rtl/nibble_word_fifo.sv
// rtl/nibble_word_fifo.sv - registered word FIFO with occupancy count
module nibble_word_fifo #(
  parameter int DEPTH  = 2,
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WORD_W-1:0]       push_data,
  input  logic                    pop,
  output logic [WORD_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/input_deserializer.sv
// rtl/input_deserializer.sv - collects nibbles into 32-bit words and queues them for the consumer
module input_deserializer
  import nibble_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int GAP_MAX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              serial_in,
  input  logic                    serial_valid,
  output logic [31:0]             word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_error,
  output logic                    overflow,
  output logic                    deser_busy,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [2:0]       LAST_NIB = 3'(NIBBLES_PER_WORD - 1);

  deser_state_t      state;
  logic [2:0]        nib_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] next_shift;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;

  assign next_shift = shift_nibble(shift, serial_in);
  assign push       = (state == DS_COLLECT) && serial_valid && (nib_cnt == LAST_NIB);
  assign word_valid = !fifo_empty;
  assign deser_busy = (state == DS_COLLECT);

  nibble_word_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (next_shift),
    .pop       (word_ready),
    .rd_data   (word_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DS_IDLE;
      nib_cnt     <= '0;
      gap_cnt     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      // Full implies non-empty, so word_ready alone tells whether a pop makes room.
      overflow    <= push && fifo_full && !word_ready;
      case (state)
        DS_IDLE: begin
          if (serial_valid) begin
            shift   <= next_shift;
            nib_cnt <= 3'd1;
            gap_cnt <= '0;
            state   <= DS_COLLECT;
          end
        end
        DS_COLLECT: begin
          if (serial_valid) begin
            shift   <= next_shift;
            gap_cnt <= '0;
            if (nib_cnt == LAST_NIB) begin
              nib_cnt <= '0;
              state   <= DS_IDLE;
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end else if (gap_cnt == GAP_LIM) begin
            frame_error <= 1'b1;
            nib_cnt     <= '0;
            gap_cnt     <= '0;
            shift       <= '0;
            state       <= DS_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_deserializer.sv
// tb/tb_input_deserializer.sv - scoreboard bench for input_deserializer (GAP_MAX 0 and 2 instances)
module tb_input_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  si0 = '0, si2 = '0;
  logic        sv0 = 1'b0, sv2 = 1'b0;
  logic        rdy0 = 1'b0, rdy2 = 1'b0;
  logic [31:0] wo0, wo2;
  logic        wv0, wv2, fe0_o, fe2_o, ov0_o, ov2_o, busy0, busy2;
  logic [1:0]  lvl0, lvl2;

  int n_cmp = 0;
  int n_err = 0;
  int fe0 = 0, fe2 = 0, ov0 = 0, ov2 = 0;
  logic [31:0] q0[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  input_deserializer #(.DEPTH(2), .GAP_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .serial_in(si0), .serial_valid(sv0),
    .word_out(wo0), .word_valid(wv0), .word_ready(rdy0),
    .frame_error(fe0_o), .overflow(ov0_o), .deser_busy(busy0), .fifo_level(lvl0)
  );

  input_deserializer #(.DEPTH(2), .GAP_MAX(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .serial_in(si2), .serial_valid(sv2),
    .word_out(wo2), .word_valid(wv2), .word_ready(rdy2),
    .frame_error(fe2_o), .overflow(ov2_o), .deser_busy(busy2), .fifo_level(lvl2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever the DUT hands over a word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wv0 && rdy0) begin
        if (q0.size() == 0) check("dut0_unexpected_word", wo0, 32'hxxxxxxxx);
        else check("dut0_word", wo0, q0.pop_front());
      end
      if (wv2 && rdy2) begin
        if (q2.size() == 0) check("dut2_unexpected_word", wo2, 32'hxxxxxxxx);
        else check("dut2_word", wo2, q2.pop_front());
      end
      if (fe0_o) fe0++;
      if (fe2_o) fe2++;
      if (ov0_o) ov0++;
      if (ov2_o) ov2++;
    end
  end

  task automatic nib(input int sel, input logic [3:0] d);
    if (sel == 0) begin si0 = d; sv0 = 1'b1; end
    else          begin si2 = d; sv2 = 1'b1; end
    @(posedge clk); #1;
    sv0 = 1'b0; sv2 = 1'b0;
  endtask

  task automatic idle(input int n);
    sv0 = 1'b0; sv2 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input bit keep);
    if (keep) begin
      if (sel == 0) q0.push_back(w); else q2.push_back(w);
    end
    for (int i = 0; i < 8; i++) nib(sel, w[4*i +: 4]);
  endtask

  task automatic drain();
    rdy0 = 1'b1; rdy2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (q0.size() == 0 && q2.size() == 0 && !wv0 && !wv2) break;
      @(posedge clk); #1;
    end
    check("drain_q0_left", 32'(q0.size()), 32'd0);
    check("drain_q2_left", 32'(q2.size()), 32'd0);
    check("drain_lvl0", 32'(lvl0), 32'd0);
    check("drain_lvl2", 32'(lvl2), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_word_out", wo0, 32'h0);
    check("rst_word_valid", 32'(wv0), 32'd0);
    check("rst_level", 32'(lvl0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_flags", {30'b0, fe0_o, ov0_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single word, nibbles 1..8, consumer ready
    rdy0 = 1'b1;
    q0.push_back(32'h87654321);
    for (int i = 0; i < 7; i++) nib(0, 4'(i + 1));
    check("t1_busy_mid", 32'(busy0), 32'd1);
    check("t1_valid_before", 32'(wv0), 32'd0);
    nib(0, 4'd8);
    check("t1_valid_after", 32'(wv0), 32'd1);
    check("t1_busy_after", 32'(busy0), 32'd0);
    idle(1);
    check("t1_valid_drop", 32'(wv0), 32'd0);
    check("t1_level", 32'(lvl0), 32'd0);

    // 2: three back-to-back words into a stalled consumer
    rdy0 = 1'b0;
    send_word(0, 32'hDEADBEEF, 1'b1);
    send_word(0, 32'h12345678, 1'b1);
    check("t2_level2", 32'(lvl0), 32'd2);
    send_word(0, 32'hCAFEF00D, 1'b0);
    check("t2_overflow", 32'(ov0_o), 32'd1);
    idle(1);
    check("t2_overflow_gone", 32'(ov0_o), 32'd0);
    check("t2_level_kept", 32'(lvl0), 32'd2);
    drain();
    check("t2_ov_count", 32'(ov0), 32'd1);

    // 3: GAP_MAX=0, partial word broken by one idle cycle
    nib(0, 4'h1); nib(0, 4'h2); nib(0, 4'h3);
    idle(1);
    check("t3_frame_error", 32'(fe0_o), 32'd1);
    check("t3_busy", 32'(busy0), 32'd0);
    send_word(0, 32'hA5A5A5A5, 1'b1);
    drain();
    check("t3_fe_count", 32'(fe0), 32'd1);

    // 4: GAP_MAX=2, two idle cycles tolerated, three abort
    q2.push_back(32'h87654321);
    nib(2, 4'h1); nib(2, 4'h2); nib(2, 4'h3); nib(2, 4'h4);
    idle(2);
    check("t4_busy_in_gap", 32'(busy2), 32'd1);
    nib(2, 4'h5); nib(2, 4'h6); nib(2, 4'h7); nib(2, 4'h8);
    drain();
    check("t4_no_fe", 32'(fe2), 32'd0);
    nib(2, 4'h1); nib(2, 4'h2); nib(2, 4'h3); nib(2, 4'h4);
    idle(3);
    check("t4_frame_error", 32'(fe2_o), 32'd1);
    send_word(2, 32'h0BADF00D, 1'b1);
    drain();
    check("t4_fe_count", 32'(fe2), 32'd1);

    // 5: FIFO full, pop and 8th nibble in the same cycle
    rdy0 = 1'b0;
    send_word(0, 32'hFEEDFACE, 1'b1);
    send_word(0, 32'h01234567, 1'b1);
    q0.push_back(32'h89ABCDEF);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) rdy0 = 1'b1;
      nib(0, 4'(32'h89ABCDEF >> (4 * i)));
    end
    check("t5_level", 32'(lvl0), 32'd2);
    check("t5_no_overflow", 32'(ov0_o), 32'd0);
    drain();
    check("t5_ov_count", 32'(ov0), 32'd1);

    // 6: reset mid-word with a word queued
    rdy0 = 1'b0;
    send_word(0, 32'h55AA33CC, 1'b1);
    for (int i = 0; i < 5; i++) nib(0, 4'(i + 9));
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(wv0), 32'd0);
    check("t6_level", 32'(lvl0), 32'd0);
    check("t6_busy", 32'(busy0), 32'd0);
    check("t6_word_out", wo0, 32'h0);
    q0.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b1;
    send_word(0, 32'h13579BDF, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
